// File: rtl/rlt_collect_fifo_if.sv
// Handshake bundle between the rlt producer, the collect FIFO and its consumer.
// The hwm signal exists only when RLT_FIFO_HWM_EN is defined.
interface rlt_collect_fifo_if #(
   parameter int WIDTH = 73,
   parameter int DEPTH = 8
);
   localparam int AW = $clog2(DEPTH);

   logic             flush;
   logic             rlt_vld;
   logic [WIDTH-1:0] rlt;
   logic             out_vld;
   logic             out_rdy;
   logic [WIDTH-1:0] out_data;
   logic [AW:0]      count;
   logic             full;
   logic             ovf;
   logic             clr_ovf;
`ifdef RLT_FIFO_HWM_EN
   logic [AW:0]      hwm;

   modport master (
      output flush, rlt_vld, rlt, out_rdy, clr_ovf,
      input  out_vld, out_data, count, full, ovf, hwm
   );

   modport slave (
      input  flush, rlt_vld, rlt, out_rdy, clr_ovf,
      output out_vld, out_data, count, full, ovf, hwm
   );
`else
   modport master (
      output flush, rlt_vld, rlt, out_rdy, clr_ovf,
      input  out_vld, out_data, count, full, ovf
   );

   modport slave (
      input  flush, rlt_vld, rlt, out_rdy, clr_ovf,
      output out_vld, out_data, count, full, ovf
   );
`endif
endinterface

// File: rtl/rlt_collect_fifo.sv
// Collects rlt words into a DEPTH-entry FIFO; drops and flags words when full.
// Optional high-water mark output enabled by defining RLT_FIFO_HWM_EN.
module rlt_collect_fifo #(
   parameter int WIDTH = 73,
   parameter int DEPTH = 8
) (
   input logic             clk,
   input logic             rst_n,
   rlt_collect_fifo_if.slave bus
);
   localparam int AW = $clog2(DEPTH);
   localparam logic [AW:0] ONE      = (AW+1)'(1);
   localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW:0]      wr_ptr;
   logic [AW:0]      rd_ptr;
   logic [AW:0]      cnt;
   logic [AW:0]      cnt_nxt;
   logic             ovf_q;
   logic             full_w;
   logic             vld_w;
   logic             push;
   logic             pop;
   logic             drop;

   assign full_w = (cnt == FULL_CNT);
   assign vld_w  = (cnt != '0);

   // full is taken from the registered count, so a pop never frees room
   // for a word arriving in the same cycle
   assign push = bus.rlt_vld & ~full_w;
   assign pop  = vld_w & bus.out_rdy;
   assign drop = bus.rlt_vld & full_w;

   always_comb begin
      cnt_nxt = cnt;
      if (bus.flush) begin
         cnt_nxt = '0;
      end else if (push & ~pop) begin
         cnt_nxt = cnt + ONE;
      end else if (pop & ~push) begin
         cnt_nxt = cnt - ONE;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         cnt    <= '0;
      end else if (bus.flush) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         cnt    <= '0;
      end else begin
         if (push) begin
            wr_ptr <= wr_ptr + ONE;
         end
         if (pop) begin
            rd_ptr <= rd_ptr + ONE;
         end
         cnt <= cnt_nxt;
      end
   end

   always_ff @(posedge clk) begin
      if (push & ~bus.flush) begin
         mem[wr_ptr[AW-1:0]] <= bus.rlt;
      end
   end

   // a drop in the same cycle as a clear leaves the flag set
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ovf_q <= 1'b0;
      end else if (drop) begin
         ovf_q <= 1'b1;
      end else if (bus.clr_ovf) begin
         ovf_q <= 1'b0;
      end
   end

   assign bus.out_vld  = vld_w;
   assign bus.out_data = vld_w ? mem[rd_ptr[AW-1:0]] : '0;
   assign bus.count    = cnt;
   assign bus.full     = full_w;
   assign bus.ovf      = ovf_q;

`ifdef RLT_FIFO_HWM_EN
   logic [AW:0] hwm_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         hwm_q <= '0;
      end else if (bus.clr_ovf) begin
         hwm_q <= cnt_nxt;
      end else if (cnt_nxt > hwm_q) begin
         hwm_q <= cnt_nxt;
      end
   end

   assign bus.hwm = hwm_q;
`endif
endmodule

// File: tb/tb_rlt_collect_fifo.sv
// Directed bench for rlt_collect_fifo: reset, ordering, overflow, wrap, flush.
// Checks hwm too when RLT_FIFO_HWM_EN is defined.
module tb_rlt_collect_fifo;
   localparam int WIDTH = 73;
   localparam int DEPTH = 8;
   localparam int AW    = $clog2(DEPTH);

   logic clk;
   logic rst_n;
   int   tests;
   int   fails;

   rlt_collect_fifo_if #(.WIDTH(WIDTH), .DEPTH(DEPTH)) bus ();

   rlt_collect_fifo #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // inputs change and outputs are read 1 time unit after the rising edge
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic idle();
      bus.flush   = 1'b0;
      bus.rlt_vld = 1'b0;
      bus.rlt     = '0;
      bus.out_rdy = 1'b0;
      bus.clr_ovf = 1'b0;
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      for (int i = 0; i < 4; i++) begin
         bus.flush   = 1'($urandom);
         bus.rlt_vld = 1'($urandom);
         bus.rlt     = WIDTH'({$urandom, $urandom, $urandom});
         bus.out_rdy = 1'($urandom);
         bus.clr_ovf = 1'($urandom);
         step();
      end
      tests++;
      if (bus.out_vld !== 1'b0 || bus.count !== '0 ||
          bus.full !== 1'b0 || bus.ovf !== 1'b0) begin
         fails++;
         $display("FAIL reset_hold vld=%b cnt=%0d full=%b ovf=%b want 0 0 0 0",
                  bus.out_vld, bus.count, bus.full, bus.ovf);
      end
      idle();
      rst_n = 1'b1;
      step();
      step();
      tests++;
      if (bus.out_vld !== 1'b0 || bus.count !== '0 ||
          bus.out_data !== '0 || bus.ovf !== 1'b0) begin
         fails++;
         $display("FAIL reset_release vld=%b cnt=%0d data=%h ovf=%b want 0 0 0 0",
                  bus.out_vld, bus.count, bus.out_data, bus.ovf);
      end
`ifdef RLT_FIFO_HWM_EN
      tests++;
      if (bus.hwm !== '0) begin
         fails++;
         $display("FAIL reset_hwm got=%0d want=0", bus.hwm);
      end
`endif
   endtask

   task automatic test_pass_through();
      int peak;
      peak = 0;
      bus.out_rdy = 1'b1;
      for (int i = 1; i <= 3; i++) begin
         bus.rlt_vld = 1'b1;
         bus.rlt     = WIDTH'(i);
         step();
         if (int'(bus.count) > peak) peak = int'(bus.count);
         tests++;
         if (bus.out_vld !== 1'b1 || bus.out_data !== WIDTH'(i)) begin
            fails++;
            $display("FAIL pass_data%0d vld=%b data=%h want 1 %h",
                     i, bus.out_vld, bus.out_data, WIDTH'(i));
         end
      end
      bus.rlt_vld = 1'b0;
      step();
      tests++;
      if (peak != 1 || bus.count !== '0 || bus.out_vld !== 1'b0) begin
         fails++;
         $display("FAIL pass_count peak=%0d cnt=%0d vld=%b want 1 0 0",
                  peak, bus.count, bus.out_vld);
      end
      idle();
   endtask

   task automatic test_fill_overflow();
      bus.out_rdy = 1'b0;
      for (int i = 1; i <= 9; i++) begin
         bus.rlt_vld = 1'b1;
         bus.rlt     = WIDTH'(i);
         step();
         if (i == 8) begin
            tests++;
            if (bus.full !== 1'b1 || bus.count !== (AW+1)'(8) ||
                bus.ovf !== 1'b0) begin
               fails++;
               $display("FAIL fill_full full=%b cnt=%0d ovf=%b want 1 8 0",
                        bus.full, bus.count, bus.ovf);
            end
         end
      end
      tests++;
      if (bus.ovf !== 1'b1 || bus.count !== (AW+1)'(8)) begin
         fails++;
         $display("FAIL fill_drop ovf=%b cnt=%0d want 1 8", bus.ovf, bus.count);
      end
      bus.rlt     = WIDTH'(99);
      bus.clr_ovf = 1'b1;
      step();
      tests++;
      if (bus.ovf !== 1'b1) begin
         fails++;
         $display("FAIL set_wins ovf=%b want 1", bus.ovf);
      end
      bus.clr_ovf = 1'b0;
      bus.rlt_vld = 1'b0;
      bus.out_rdy = 1'b1;
      for (int i = 1; i <= 8; i++) begin
         tests++;
         if (bus.out_vld !== 1'b1 || bus.out_data !== WIDTH'(i)) begin
            fails++;
            $display("FAIL drain%0d vld=%b data=%h want 1 %h",
                     i, bus.out_vld, bus.out_data, WIDTH'(i));
         end
         step();
      end
      tests++;
      if (bus.count !== '0 || bus.out_vld !== 1'b0 || bus.full !== 1'b0) begin
         fails++;
         $display("FAIL drain_empty cnt=%0d vld=%b full=%b want 0 0 0",
                  bus.count, bus.out_vld, bus.full);
      end
      bus.out_rdy = 1'b0;
      bus.clr_ovf = 1'b1;
      step();
      bus.clr_ovf = 1'b0;
      tests++;
      if (bus.ovf !== 1'b0) begin
         fails++;
         $display("FAIL clr_ovf ovf=%b want 0", bus.ovf);
      end
      idle();
   endtask

   task automatic test_full_push_pop();
      bus.out_rdy = 1'b0;
      for (int i = 0; i < 8; i++) begin
         bus.rlt_vld = 1'b1;
         bus.rlt     = WIDTH'(16 + i);
         step();
      end
      bus.rlt     = WIDTH'(170);
      bus.out_rdy = 1'b1;
      step();
      tests++;
      if (bus.count !== (AW+1)'(7) || bus.ovf !== 1'b1 || bus.full !== 1'b0) begin
         fails++;
         $display("FAIL full_pushpop cnt=%0d ovf=%b full=%b want 7 1 0",
                  bus.count, bus.ovf, bus.full);
      end
      bus.rlt_vld = 1'b0;
      for (int i = 1; i < 8; i++) begin
         tests++;
         if (bus.out_data !== WIDTH'(16 + i)) begin
            fails++;
            $display("FAIL full_drain%0d data=%h want %h",
                     i, bus.out_data, WIDTH'(16 + i));
         end
         step();
      end
      tests++;
      if (bus.out_vld !== 1'b0) begin
         fails++;
         $display("FAIL full_drain_end vld=%b want 0", bus.out_vld);
      end
      bus.out_rdy = 1'b0;
      bus.clr_ovf = 1'b1;
      step();
      idle();
   endtask

   task automatic test_wrap();
      int bad;
      bad = 0;
      bus.out_rdy = 1'b0;
      for (int i = 0; i < 3; i++) begin
         bus.rlt_vld = 1'b1;
         bus.rlt     = WIDTH'(100 + i);
         step();
      end
      bus.out_rdy = 1'b1;
      for (int i = 0; i < 20; i++) begin
         bus.rlt = WIDTH'(103 + i);
         tests++;
         if (bus.out_data !== WIDTH'(100 + i)) begin
            fails++;
            $display("FAIL wrap_data%0d data=%h want %h",
                     i, bus.out_data, WIDTH'(100 + i));
         end
         step();
         if (bus.count !== (AW+1)'(3) || bus.full !== 1'b0) bad++;
      end
      tests++;
      if (bad != 0) begin
         fails++;
         $display("FAIL wrap_level bad_cycles=%0d want 0", bad);
      end
      bus.rlt_vld = 1'b0;
      for (int i = 0; i < 3; i++) begin
         tests++;
         if (bus.out_data !== WIDTH'(120 + i)) begin
            fails++;
            $display("FAIL wrap_tail%0d data=%h want %h",
                     i, bus.out_data, WIDTH'(120 + i));
         end
         step();
      end
      idle();
   endtask

   task automatic test_flush_hwm();
      bus.clr_ovf = 1'b1;
      step();
      bus.clr_ovf = 1'b0;
      for (int i = 0; i < 9; i++) begin
         bus.rlt_vld = 1'b1;
         bus.rlt     = WIDTH'(200 + i);
         step();
      end
      bus.flush   = 1'b1;
      bus.out_rdy = 1'b1;
      step();
      bus.flush   = 1'b0;
      bus.rlt_vld = 1'b0;
      bus.out_rdy = 1'b0;
      tests++;
      if (bus.count !== '0 || bus.out_vld !== 1'b0 || bus.ovf !== 1'b1) begin
         fails++;
         $display("FAIL flush_full cnt=%0d vld=%b ovf=%b want 0 0 1",
                  bus.count, bus.out_vld, bus.ovf);
      end
`ifdef RLT_FIFO_HWM_EN
      tests++;
      if (bus.hwm !== (AW+1)'(8)) begin
         fails++;
         $display("FAIL hwm_full got=%0d want=8", bus.hwm);
      end
`endif
      bus.clr_ovf = 1'b1;
      step();
      bus.clr_ovf = 1'b0;
      for (int i = 0; i < 5; i++) begin
         bus.rlt_vld = 1'b1;
         bus.rlt     = WIDTH'(300 + i);
         step();
      end
      bus.rlt_vld = 1'b0;
      tests++;
      if (bus.count !== (AW+1)'(5) || bus.out_data !== WIDTH'(300)) begin
         fails++;
         $display("FAIL five_words cnt=%0d data=%h want 5 %h",
                  bus.count, bus.out_data, WIDTH'(300));
      end
      bus.flush = 1'b1;
      step();
      bus.flush = 1'b0;
      tests++;
      if (bus.count !== '0 || bus.out_vld !== 1'b0 ||
          bus.ovf !== 1'b0 || bus.out_data !== '0) begin
         fails++;
         $display("FAIL flush_five cnt=%0d vld=%b ovf=%b data=%h want 0 0 0 0",
                  bus.count, bus.out_vld, bus.ovf, bus.out_data);
      end
`ifdef RLT_FIFO_HWM_EN
      step();
      tests++;
      if (bus.hwm !== (AW+1)'(5)) begin
         fails++;
         $display("FAIL hwm_hold got=%0d want=5", bus.hwm);
      end
      bus.clr_ovf = 1'b1;
      step();
      bus.clr_ovf = 1'b0;
      tests++;
      if (bus.hwm !== '0) begin
         fails++;
         $display("FAIL hwm_clear got=%0d want=0", bus.hwm);
      end
`endif
      idle();
   endtask

   task automatic test_async_reset();
      for (int i = 0; i < 2; i++) begin
         bus.rlt_vld = 1'b1;
         bus.rlt     = WIDTH'(400 + i);
         step();
      end
      bus.rlt_vld = 1'b0;
      #2;
      rst_n = 1'b0;
      #1;
      tests++;
      if (bus.out_vld !== 1'b0 || bus.count !== '0) begin
         fails++;
         $display("FAIL async_reset vld=%b cnt=%0d want 0 0",
                  bus.out_vld, bus.count);
      end
      step();
      rst_n = 1'b1;
      step();
      tests++;
      if (bus.out_vld !== 1'b0 || bus.out_data !== '0) begin
         fails++;
         $display("FAIL async_release vld=%b data=%h want 0 0",
                  bus.out_vld, bus.out_data);
      end
      idle();
   endtask

   initial begin
      tests = 0;
      fails = 0;
      idle();
      rst_n = 1'b0;
      test_reset();
      test_pass_through();
      test_fill_overflow();
      test_full_push_pop();
      test_wrap();
      test_flush_hwm();
      test_async_reset();
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
